// File: rtl/average_filter_scheduler.sv
// rtl/average_filter_scheduler.sv - round-robin shared two-stage pairwise averaging filter
module average_filter_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_en,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_clear,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_ce,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(NUM_CH)-1:0]    o_ch,
    output logic                         o_busy
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0]              ptr;
    logic [CH_W-1:0]              gnt_ch;
    logic                         gnt_any;
    logic                         accept;
    logic [DATA_WIDTH-1:0]        gnt_sample;
    logic [DATA_WIDTH-1:0]        gnt_last;
    logic [DATA_WIDTH:0]          sum_next;
    logic [DATA_WIDTH-1:0]        last_q [NUM_CH];
    logic [NUM_CH-1:0]            primed_q;
    logic                         s1_valid;
    logic [CH_W-1:0]              s1_ch;
    logic signed [DATA_WIDTH:0]   s1_sum;

    // Search from ptr upward; NUM_CH is a power of two so the index wraps for free.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && i_valid[ptr + CH_W'(i)]) begin
                gnt_any = 1'b1;
                gnt_ch  = ptr + CH_W'(i);
            end
        end
    end

    assign accept  = gnt_any && i_en && !reset;
    assign o_ready = accept ? (NUM_CH'(1) << gnt_ch) : '0;
    assign o_busy  = s1_valid | o_ce;

    always_comb begin
        gnt_sample = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_ch == CH_W'(c)) begin
                gnt_sample = i_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        gnt_last = last_q[gnt_ch];
        // A clear landing with the sample makes it behave as the first of a fresh history.
        if (primed_q[gnt_ch] && !i_clear[gnt_ch]) begin
            sum_next = {gnt_sample[DATA_WIDTH-1], gnt_sample} + {gnt_last[DATA_WIDTH-1], gnt_last};
        end else begin
            sum_next = {gnt_sample, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            primed_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                last_q[c] <= '0;
            end
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_sum   <= '0;
            o_ce     <= 1'b0;
            data_out <= '0;
            o_ch     <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept && gnt_ch == CH_W'(c)) begin
                    last_q[c]   <= gnt_sample;
                    primed_q[c] <= 1'b1;
                end else if (i_clear[c]) begin
                    last_q[c]   <= '0;
                    primed_q[c] <= 1'b0;
                end
            end
            if (accept) begin
                ptr    <= gnt_ch + CH_W'(1);
                s1_ch  <= gnt_ch;
                s1_sum <= sum_next;
            end
            s1_valid <= accept;
            o_ce     <= s1_valid;
            if (s1_valid) begin
                data_out <= DATA_WIDTH'(s1_sum >>> 1);
                o_ch     <= s1_ch;
            end
        end
    end
endmodule

// File: tb/tb_average_filter_scheduler.sv
// tb/tb_average_filter_scheduler.sv - randomized and directed bench with a queue-based reference model
module tb_average_filter_scheduler;
    localparam int DW  = 8;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_en;
    logic [NCH-1:0]    i_valid;
    logic [NCH*DW-1:0] i_data;
    logic [NCH-1:0]    i_clear;
    logic [NCH-1:0]    o_ready;
    logic              o_ce;
    logic [DW-1:0]     data_out;
    logic [1:0]        o_ch;
    logic              o_busy;

    average_filter_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .clk(clk), .reset(reset), .i_en(i_en), .i_valid(i_valid), .i_data(i_data),
        .i_clear(i_clear), .o_ready(o_ready), .o_ce(o_ce), .data_out(data_out),
        .o_ch(o_ch), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // floor((a+b)/2) with plain integer arithmetic
    function automatic int avg2(input int a, input int b);
        int s;
        s = a + b;
        if (s >= 0) return s / 2;
        return -((1 - s) / 2);
    endfunction

    typedef struct {
        int due;
        int ch;
        int val;
    } item_t;

    item_t pipe_q[$];
    int    obs_val[$];
    int    obs_ch[$];
    int    gnt_log[$];
    int    mlast[NCH];
    bit    mprimed[NCH];
    int    mp = 0;
    int    m_data = 0;
    int    m_ch = 0;
    int    cyc = 0;
    int    g, s, v;
    bit    exp_ce, exp_busy;

    initial begin
        for (int c = 0; c < NCH; c++) begin
            mlast[c]   = 0;
            mprimed[c] = 0;
        end
    end

    // Inputs change 2 time units after a rising edge, so the falling edge sees them stable.
    always @(negedge clk) begin
        cyc++;
        exp_ce   = 1'b0;
        exp_busy = (pipe_q.size() > 0);
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            exp_ce = 1'b1;
            m_data = pipe_q[0].val;
            m_ch   = pipe_q[0].ch;
            void'(pipe_q.pop_front());
        end
        g = -1;
        if (!reset && i_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (g < 0 && i_valid[(mp + i) % NCH]) g = (mp + i) % NCH;
            end
        end
        chk("o_ready", int'(o_ready), (g < 0) ? 0 : (1 << g));
        chk("o_ce", int'(o_ce), int'(exp_ce));
        chk("data_out", $signed(data_out), m_data);
        chk("o_ch", int'(o_ch), m_ch);
        chk("o_busy", int'(o_busy), int'(exp_busy));
        if (o_ce) begin
            obs_val.push_back($signed(data_out));
            obs_ch.push_back(int'(o_ch));
        end
        if (g >= 0) gnt_log.push_back(g);

        if (reset) begin
            mp = 0;
            m_data = 0;
            m_ch = 0;
            pipe_q.delete();
            for (int c = 0; c < NCH; c++) begin
                mlast[c]   = 0;
                mprimed[c] = 0;
            end
        end else begin
            if (g >= 0) begin
                s = $signed(i_data[g*DW +: DW]);
                v = (mprimed[g] && !i_clear[g]) ? avg2(s, mlast[g]) : s;
                pipe_q.push_back('{cyc + 2, g, v});
            end
            for (int c = 0; c < NCH; c++) begin
                if (c == g) begin
                    mlast[c]   = s;
                    mprimed[c] = 1;
                end else if (i_clear[c]) begin
                    mlast[c]   = 0;
                    mprimed[c] = 0;
                end
            end
            if (g >= 0) mp = (g + 1) % NCH;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        i_valid = '0;
        i_clear = '0;
        repeat (n) tick();
    endtask

    task automatic send(input int ch, input int val, input bit clr);
        i_valid = '0;
        i_clear = '0;
        i_valid[ch] = 1'b1;
        i_clear[ch] = clr;
        i_data[ch*DW +: DW] = DW'(val);
        tick();
    endtask

    task automatic clear_logs();
        obs_val.delete();
        obs_ch.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    int exp_single[4] = '{10, -5, 5, -5};
    int ext_vals[10]  = '{100, -127, 127, -60, -127, 127, -128, -128, 127, 127};
    int ext_exp[5]    = '{-14, 33, 0, -128, 127};

    initial begin
        reset   = 1'b1;
        i_en    = 1'b1;
        i_valid = '1;
        i_data  = '0;
        i_clear = '0;
        #1;
        chk("reset_ready", int'(o_ready), 0);
        tick();
        chk("reset_ce", int'(o_ce), 0);
        chk("reset_data", int'(data_out), 0);
        chk("reset_busy", int'(o_busy), 0);
        i_valid = '0;
        tick();

        // first acceptance lands on the first edge after reset falls
        reset = 1'b0;
        clear_logs();
        send(0, 10, 0);
        send(0, -20, 0);
        send(0, 30, 0);
        send(0, -40, 0);
        idle(4);
        chk("single_count", obs_val.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_val.size()) begin
                chk("single_val", obs_val[i], exp_single[i]);
                chk("single_ch", obs_ch[i], 0);
            end
        end

        do_reset();
        clear_logs();
        i_valid = '1;
        repeat (8) tick();
        idle(4);
        chk("fair_grants", gnt_log.size(), 8);
        chk("fair_outs", obs_ch.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) chk("fair_grant", gnt_log[i], i % 4);
            if (i < obs_ch.size()) chk("fair_och", obs_ch[i], i % 4);
        end

        do_reset();
        clear_logs();
        for (int i = 0; i < 10; i++) send(1, ext_vals[i], 0);
        idle(4);
        chk("ext_count", obs_val.size(), 10);
        for (int i = 0; i < 5; i++) begin
            if (2*i + 1 < obs_val.size()) chk("ext_val", obs_val[2*i + 1], ext_exp[i]);
        end

        do_reset();
        clear_logs();
        send(2, 50, 0);
        send(2, 20, 1);
        send(2, 40, 0);
        idle(4);
        chk("clr_count", obs_val.size(), 3);
        if (obs_val.size() == 3) begin
            chk("clr_collide", obs_val[1], 20);
            chk("clr_next", obs_val[2], 30);
            chk("clr_ch", obs_ch[2], 2);
        end

        clear_logs();
        send(0, 99, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send(0, 8, 0);
        idle(4);
        chk("midrst_count", obs_val.size(), 1);
        if (obs_val.size() == 1) chk("midrst_val", obs_val[0], 8);

        for (int n = 0; n < 3000; n++) begin
            i_en    = ($urandom_range(0, 9) != 0);
            reset   = ($urandom_range(0, 199) == 0);
            i_valid = NCH'($urandom);
            i_data  = (NCH*DW)'($urandom);
            i_clear = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            tick();
        end
        reset = 1'b0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
